// File: rtl/slave_req_scheduler.sv
// Per-slave request scheduler: round-robin grant between two masters, command
// forwarding to one slave, and an in-order tag FIFO that steers read data back.
module slave_req_scheduler #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int SLAVE_ID  = 0,
  parameter int TAG_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m0_cmd,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic              m1_req,
  input  logic              m1_cmd,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_ack,
  output logic              m1_ack,
  output logic              m0_resp,
  output logic              m1_resp,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              s_req,
  output logic              s_cmd,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_wdata,
  input  logic              s_ack,
  input  logic              s_resp,
  input  logic [DATA_W-1:0] s_rdata,
  output logic              proto_err
);

  localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(TAG_DEPTH);
  localparam logic SLAVE_BIT = (SLAVE_ID != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t                 state_r;
  logic                   last_mas_r;
  logic [TAG_DEPTH-1:0]   tag_mem_r;
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic                   proto_err_r;

  logic elig0_s;
  logic elig1_s;
  logic full_s;
  logic accept_s;
  logic push_s;
  logic pop_s;
  logic head_tag_s;

  assign elig0_s  = m0_req & (m0_addr[ADDR_W-1] == SLAVE_BIT);
  assign elig1_s  = m1_req & (m1_addr[ADDR_W-1] == SLAVE_BIT);
  assign full_s   = (count_r == FULL_CNT);
  assign accept_s = s_req & s_ack;
  assign push_s   = accept_s & ~s_cmd;
  assign pop_s    = s_resp & (count_r != {CNT_W{1'b0}});
  assign head_tag_s = tag_mem_r[rd_ptr_r];
  assign proto_err  = proto_err_r;

  // Forward the granted master's command; the slave sees nothing outside a grant.
  always_comb begin
    s_req   = 1'b0;
    s_cmd   = 1'b0;
    s_addr  = {ADDR_W{1'b0}};
    s_wdata = {DATA_W{1'b0}};
    case (state_r)
      GRANT0: begin
        s_req   = elig0_s & ~full_s;
        s_cmd   = m0_cmd;
        s_addr  = m0_addr;
        s_wdata = m0_wdata;
      end
      GRANT1: begin
        s_req   = elig1_s & ~full_s;
        s_cmd   = m1_cmd;
        s_addr  = m1_addr;
        s_wdata = m1_wdata;
      end
      default: begin
        s_req   = 1'b0;
        s_cmd   = 1'b0;
        s_addr  = {ADDR_W{1'b0}};
        s_wdata = {DATA_W{1'b0}};
      end
    endcase
  end

  // Route the accept back to the granted master and read data to the head tag owner.
  always_comb begin
    m0_ack   = accept_s & (state_r == GRANT0);
    m1_ack   = accept_s & (state_r == GRANT1);
    m0_resp  = pop_s & ~head_tag_s;
    m1_resp  = pop_s & head_tag_s;
    m0_rdata = {DATA_W{1'b0}};
    m1_rdata = {DATA_W{1'b0}};
    if (m0_resp) begin
      m0_rdata = s_rdata;
    end else begin
      m0_rdata = {DATA_W{1'b0}};
    end
    if (m1_resp) begin
      m1_rdata = s_rdata;
    end else begin
      m1_rdata = {DATA_W{1'b0}};
    end
  end

  // Grant state machine; a dropped or retargeted request abandons the grant without touching priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      last_mas_r <= 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          if (elig0_s && elig1_s) begin
            state_r <= last_mas_r ? GRANT0 : GRANT1;
          end else if (elig0_s) begin
            state_r <= GRANT0;
          end else if (elig1_s) begin
            state_r <= GRANT1;
          end else begin
            state_r <= IDLE;
          end
        end
        GRANT0: begin
          if (accept_s) begin
            last_mas_r <= 1'b0;
            state_r    <= IDLE;
          end else if (!elig0_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= GRANT0;
          end
        end
        GRANT1: begin
          if (accept_s) begin
            last_mas_r <= 1'b1;
            state_r    <= IDLE;
          end else if (!elig1_s) begin
            state_r <= IDLE;
          end else begin
            state_r <= GRANT1;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  // Outstanding-read tag FIFO and sticky protocol error on an unexpected response.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_mem_r   <= {TAG_DEPTH{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      proto_err_r <= 1'b0;
    end else begin
      if (push_s) begin
        tag_mem_r[wr_ptr_r] <= (state_r == GRANT1);
        wr_ptr_r            <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      if (push_s && !pop_s) begin
        count_r <= count_r + 1'b1;
      end else if (pop_s && !push_s) begin
        count_r <= count_r - 1'b1;
      end
      if (s_resp && (count_r == {CNT_W{1'b0}})) begin
        proto_err_r <= 1'b1;
      end
    end
  end

endmodule

// File: doc/slave_req_scheduler.md
Name: slave_req_scheduler

Overview:
- Per-slave clocked request scheduler for the 2-master / 2-slave interconnect. One instance per slave.
- Arbitrates round-robin between master 0 and master 1 for that slave. Forwards the winner's command to the slave and routes the slave's ack back to that master.
- Tracks outstanding reads in an in-order tag FIFO, so late read data returns to the master that issued the read.

Parameters:
- ADDR_W, 32, address width; bit ADDR_W-1 selects the target slave.
- DATA_W, 32, write/read data width.
- SLAVE_ID, 0, slave number this instance serves (0 or 1).
- TAG_DEPTH, 4, maximum outstanding reads (power of 2, ≥2).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- m0_req, m1_req  in  1  master request valid.
- m0_cmd, m1_cmd  in  1  0 = read, 1 = write.
- m0_addr, m1_addr  in  ADDR_W  request address.
- m0_wdata, m1_wdata  in  DATA_W  write data.
- m0_ack, m1_ack  out  1  request accepted by slave.
- m0_resp, m1_resp  out  1  read data valid to master.
- m0_rdata, m1_rdata  out  DATA_W  read data (0 when resp low).
- s_req  out  1  request to slave.
- s_cmd  out  1  forwarded cmd.
- s_addr  out  ADDR_W  forwarded address.
- s_wdata  out  DATA_W  forwarded write data.
- s_ack  in  1  slave accepts current s_req.
- s_resp  in  1  slave read data valid.
- s_rdata  in  DATA_W  slave read data.
- proto_err  out  1  sticky: s_resp arrived with no outstanding read.

Behaviour:
- Eligibility: mi eligible when mi_req=1 and mi_addr[ADDR_W-1]==SLAVE_ID.
- State machine (registered): IDLE, GRANT0, GRANT1.
- IDLE, one eligible master: go to GRANTi.
- IDLE, both eligible: grant the master other than last_mas.
- IDLE, none eligible: stay in IDLE.
- Reset state: IDLE, last_mas=1 (master 0 wins first tie), tag FIFO empty, proto_err=0. All outputs 0.
- In GRANTi, s_req = mi_req & eligible & (tag_count < TAG_DEPTH). s_cmd, s_addr, s_wdata mirror mi combinationally. Outside GRANTi they are 0.
- Accept when GRANTi, s_req=1 and s_ack=1 in the same cycle:
  - mi_ack=1 combinationally that cycle.
  - last_mas<=i and state<=IDLE.
  - If cmd=0, push tag i.
  - The other master's ack stays 0.
- Granted master drops req or changes slave before accept: state<=IDLE, no ack, last_mas unchanged.
- s_ack while not in GRANTx or while s_req=0: ignored.
- Tag FIFO full (count==TAG_DEPTH): s_req held 0. Grant is kept; accept resumes once a pop frees a slot. No push occurs while full.
- Response: s_resp=1 with count>0 pops the head tag h. Same cycle, mh_resp=1 and mh_rdata=s_rdata; the other master's resp=0.
- s_resp=1 with count==0: no pop, proto_err<=1 until rst.
- Push and pop in the same cycle: count unchanged; pointers wrap modulo TAG_DEPTH.
- Latency:
  - Eligible req at edge N → s_req high cycle N+1 (if slave acks immediately, mi_ack in N+1).
  - 1-cycle IDLE bubble after each accept → max one accept per 2 cycles.
- Reset mid-transaction: state IDLE, FIFO flushed, outstanding reads forgotten. A later s_resp then sets proto_err.

Test Plan:
- Reset, then m0 write to SLAVE_ID (addr MSB match), s_ack tied 1 → s_req high 1 cycle after req; m0_ack=1 that cycle; no FIFO push; state IDLE next cycle.
- Both masters request continuously, s_ack=1 → accept order m0, m1, m0, m1. Each ack exactly one cycle wide, separated by one idle cycle.
- m0 issues reads with s_resp held off, TAG_DEPTH=4 → 4 acks, then s_req stays 0. One s_resp with rdata=0xA5A5A5A5 → m0_resp=1 with that data; next s_req accepted.
- m0 read then m1 read accepted; slave returns 0x11 then 0x22 → m0_resp gets 0x11, then m1_resp gets 0x22; never cross-routed.
- m1 request with addr MSB ≠ SLAVE_ID → no grant, s_req stays 0. m0 dropping req while in GRANT0 → returns to IDLE, no ack.
- s_resp pulse with empty FIFO → proto_err=1 and held; any master resp stays 0; rst clears proto_err.
